mux_out_skid_32bit: RTL and testbench
=====================================

MUX_OUT_SKID_32BIT -- requirements
Module: mux_out_skid_32bit

Interface
- REQ-001: The block SHALL have one clock and an asynchronous, active-low reset.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: in_valid  input  1  upstream word valid. The upstream is the 32-bit 2:1 mux.
- REQ-005: in_data  input  32  selected word, taken from the upstream mux output o.
- REQ-006: in_sel  input  1  select value that produced in_data.
- REQ-007: in_ready  output  1  block can accept a word this cycle.
- REQ-008: out_valid  output  1  out_data/out_sel hold a valid word.
- REQ-009: out_data  output  32  head-of-buffer word.
- REQ-010: out_sel  output  1  select tag of the head word.
- REQ-011: out_ready  input  1  downstream accepts the head word.
- REQ-012: xfer_cnt  output  16  count of completed output transfers (see Configuration).

Function
- REQ-013: Push SHALL occur when in_valid=1 and in_ready=1 at a rising clk; pop SHALL occur when out_valid=1 and out_ready=1 at a rising clk.
- REQ-014: Storage SHALL be a 2-entry FIFO: a head register driving out_*, plus one skid register. Each entry holds {data[31:0], sel}.
- REQ-015: FSM states: EMPTY (0 words), ONE (1 word), FULL (2 words). The state SHALL be registered.
- REQ-016: Transitions:
  - EMPTY + push -> ONE.
  - ONE + push only -> FULL.
  - ONE + pop only -> EMPTY.
  - ONE + push + pop -> ONE.
  - FULL + pop -> ONE.
  - All other cases hold the current state.
- REQ-017: in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL. It SHALL be decoded from registered state only, with no combinational path from out_ready.
- REQ-018: out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY.
- REQ-019: Latency: a word pushed at edge N into EMPTY SHALL appear on out_data/out_sel after edge N, i.e. one cycle.
- REQ-020: In ONE with simultaneous push and pop, the head SHALL load the incoming word at the same edge. This sustains one word per cycle.
- REQ-021: In FULL with pop, the skid word SHALL move to the head at that edge. in_valid is ignored while in FULL.
- REQ-022: Ordering SHALL be strict FIFO. No word is dropped or duplicated.
- REQ-023: The head registers SHALL remain unchanged while out_valid=1 and out_ready=0.
- REQ-024: In EMPTY, out_data and out_sel SHALL hold their last values. Consumers qualify on out_valid.

Reset
- REQ-025: On rst_n=0 the block SHALL go asynchronously to EMPTY, and in any state including mid-transfer:
  - out_valid=0, in_ready=1;
  - out_data=32'h00000000, out_sel=0;
  - skid register=0, xfer_cnt=16'h0000.
- REQ-026: The first push SHALL be accepted at the first rising clk after rst_n deasserts.

Configuration
- REQ-027: The feature macro SHALL be MUX_OUT_XFER_CNT_EN.
- REQ-028: With MUX_OUT_XFER_CNT_EN defined, xfer_cnt SHALL increment by 1 on every pop and wrap from 16'hFFFF to 16'h0000.
- REQ-029: Without MUX_OUT_XFER_CNT_EN, the xfer_cnt port SHALL remain present and be tied to 16'h0000, with no counter logic.

Verification
- REQ-030: Reset then single push. Stimulus: rst_n pulse low; push in_data=32'h11111111, in_sel=0, with out_ready=1. Response: after reset, out_valid=0, in_ready=1, out_data=0; one cycle after the push, out_valid=1, out_data=32'h11111111, out_sel=0.
- REQ-031: Back-pressure fill. Stimulus: out_ready=0; push 32'hAAAABBBB (sel=1), then 32'hFFFF0000 (sel=1), then offer 32'h000FF000. Response: state FULL, in_ready=0, third word not accepted, out_data holds 32'hAAAABBBB.
- REQ-032: Drain from FULL. Stimulus: out_ready=1 from the REQ-031 state. Response: out_data sequence 32'hAAAABBBB, 32'hFFFF0000; out_valid=0 afterwards; in_ready=1 once the block has left FULL.
- REQ-033: Streaming. Stimulus: in_valid and out_ready held at 1 for 8 words 32'h00000001..32'h00000008. Response: one word out per cycle in order; the state never reaches FULL.
- REQ-034: Mid-operation reset. Stimulus: assert rst_n=0 asynchronously (between edges) while FULL. Response: out_valid=0, in_ready=1, out_data=0 immediately; no stale words appear afterwards.
- REQ-035: Counter wrap (MUX_OUT_XFER_CNT_EN defined). Stimulus: 65537 pops. Response: xfer_cnt=16'h0001. With the macro undefined, xfer_cnt stays 16'h0000 throughout.

Source files
------------

// File: rtl/mux_out_skid_32bit.sv
// mux_out_skid_32bit: 2-entry skid FIFO (head + skid register) behind a 32-bit 2:1 mux.
// Define MUX_OUT_XFER_CNT_EN to count completed output transfers on xfer_cnt.
module mux_out_skid_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_sel,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_sel,
  input  logic        out_ready,
  output logic [15:0] xfer_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                push;
  logic                pop;
  logic                head_load;
  logic                head_from_skid;
  logic                skid_load;
  logic [DATA_W-1:0]   skid_data;
  logic                skid_sel;

  // Handshakes qualify on the registered in_ready/out_valid only.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state and datapath steering.
  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_load = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = FULL;
            skid_load = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: head_load = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register; in_ready/out_valid are flopped decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Head and skid storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= 1'b0;
      skid_data <= '0;
      skid_sel  <= 1'b0;
    end else begin
      if (head_load) begin
        out_data <= head_from_skid ? skid_data : in_data;
        out_sel  <= head_from_skid ? skid_sel  : in_sel;
      end
      if (skid_load) begin
        skid_data <= in_data;
        skid_sel  <= in_sel;
      end
    end
  end

`ifdef MUX_OUT_XFER_CNT_EN
  // Wrapping count of output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_out_skid_32bit.sv
// tb_mux_out_skid_32bit: directed stimulus with a queue scoreboard for mux_out_skid_32bit.
module tb_mux_out_skid_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sel;
  logic        out_ready = 1'b0;
  logic [15:0] xfer_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic        sel;
  } ent_t;

  ent_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned pop_cnt = 0;

  mux_out_skid_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change at posedge+1; the negedge sees what the next posedge will take.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back('{data: in_data, sel: in_sel});
      if (out_valid && out_ready) begin
        ent_t e;
        pop_cnt++;
        if (sb.size() == 0) begin
          check("pop_underflow", 32'(out_data), 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          check("pop_data", out_data, e.data);
          check("pop_sel", 32'(out_sel), 32'(e.sel));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_cnt;
    bit          done;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);

    // Single push taken at the first edge after reset release
    tick();
    in_valid  = 1'b1;
    in_data   = 32'h1111_1111;
    in_sel    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data", out_data, 32'h1111_1111);
    check("single_out_sel", 32'(out_sel), 32'd0);
    tick();
    check("single_drained", 32'(out_valid), 32'd0);
    check("single_in_ready", 32'(in_ready), 32'd1);

    // Back-pressure fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_BBBB;
    in_sel    = 1'b1;
    tick();
    in_data = 32'hFFFF_0000;
    in_sel  = 1'b1;
    tick();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    in_data = 32'h000F_F000;
    in_sel  = 1'b0;
    tick();
    tick();
    check("full_hold_ready", 32'(in_ready), 32'd0);
    check("full_hold_data", out_data, 32'hAAAA_BBBB);
    check("full_hold_sel", 32'(out_sel), 32'd1);
    in_valid = 1'b0;

    // Drain from FULL
    out_ready = 1'b1;
    tick();
    check("drain_head2", out_data, 32'hFFFF_0000);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_hold_data", out_data, 32'hFFFF_0000);
    tick();
    check("drain_no_extra", 32'(out_valid), 32'd0);

    // Streaming, one word per cycle
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_sel   = i[0];
      tick();
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Mid-operation async reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_sel    = 1'b1;
    tick();
    in_data = 32'h9ABC_DEF0;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_out_sel", 32'(out_sel), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    check("post_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);

    // Transfer counter over 65537 pops
    pop_cnt   = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    done      = 1'b0;
    for (int k = 0; k < 70000 && !done; k++) begin
      in_data = 32'(k);
      in_sel  = 1'(k);
      tick();
      if (pop_cnt >= 65537) done = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("wrap_pop_budget", pop_cnt, 32'd65537);
`ifdef MUX_OUT_XFER_CNT_EN
    exp_cnt = 16'h0001;
`else
    exp_cnt = 16'h0000;
`endif
    check("wrap_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    tick();
    check("wrap_xfer_cnt_hold", 32'(xfer_cnt), 32'(exp_cnt));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
